// File: rtl/burst_timeout_arbiter.sv
// burst_timeout_arbiter: burst-locking arbiter with per-channel aging promotion.
// Define BURST_TIMEOUT_ARBITER_PREEMPT_EN to cap every grant at MAX_BURST cycles.
module burst_timeout_arbiter #(
    parameter int SIZE      = 4,
    parameter int TIMEOUT   = 8,
    parameter int MAX_BURST = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [SIZE-1:0] requests,
    input  logic [SIZE-1:0] releases,
    output logic [SIZE-1:0] grant,
    output logic            busy
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t          r_state, w_state_nx;
    logic [SIZE-1:0] r_grant, w_grant_nx, w_timed, w_pool, w_win;
    logic [CW-1:0]   r_age [1:SIZE-1];
    logic [CW-1:0]   w_age_nx [1:SIZE-1];
    logic            w_release;
    always_comb begin
        w_timed = '0;
        for (int i = 1; i < SIZE; i++) w_timed[i] = requests[i] && r_age[i] == '0;
    end
    // Timed-out requesters pre-empt plain priority; isolate the lowest set bit.
    assign w_pool = |w_timed ? w_timed : requests;
    assign w_win  = w_pool & (~w_pool + SIZE'(1));
`ifdef BURST_TIMEOUT_ARBITER_PREEMPT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] r_burst;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)             r_burst <= '0;
        else if (r_state == IDLE) r_burst <= '0;
        else                     r_burst <= r_burst + BW'(1);
    end
    assign w_release = |(r_grant & (~requests | releases)) || r_burst == BW'(MAX_BURST - 1);
`else
    assign w_release = |(r_grant & (~requests | releases));
`endif
    always_comb begin
        w_state_nx = r_state;
        w_grant_nx = r_grant;
        for (int i = 1; i < SIZE; i++) w_age_nx[i] = r_age[i];
        if (r_state == IDLE) begin
            if (|requests) begin
                w_state_nx = LOCKED;
                w_grant_nx = w_win;
                for (int i = 1; i < SIZE; i++)
                    w_age_nx[i] = w_win[i] ? CW'(TIMEOUT - 1) :
                                  (requests[i] && r_age[i] != '0) ? r_age[i] - CW'(1) : r_age[i];
            end
        end else if (w_release) begin
            w_state_nx = IDLE;
            w_grant_nx = '0;
        end
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            for (int i = 1; i < SIZE; i++) r_age[i] <= CW'(TIMEOUT - 1);
        end else begin
            r_state <= w_state_nx;
            r_grant <= w_grant_nx;
            for (int i = 1; i < SIZE; i++) r_age[i] <= w_age_nx[i];
        end
    end
    assign grant = r_grant;
    assign busy  = r_state == LOCKED;
endmodule

// File: tb/tb_burst_timeout_arbiter.sv
// tb_burst_timeout_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_burst_timeout_arbiter;
    localparam int SIZE = 4, TIMEOUT = 8, MAX_BURST = 16;
    logic            clock = 1'b0, resetn = 1'b0;
    logic [SIZE-1:0] requests = '0, releases = '0;
    logic [SIZE-1:0] grant;
    logic            busy;
    int checks = 0, failures = 0;
    int m_gnt, m_len;
    int m_age [SIZE];

    burst_timeout_arbiter #(.SIZE(SIZE), .TIMEOUT(TIMEOUT), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .resetn(resetn), .requests(requests), .releases(releases),
        .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] exp_grant();
        return m_gnt < 0 ? '0 : SIZE'(1) << m_gnt;
    endfunction

    task automatic model_reset();
        m_gnt = -1;
        m_len = 0;
        for (int i = 0; i < SIZE; i++) m_age[i] = TIMEOUT - 1;
    endtask

    // One clock of the arbiter's rules, applied to the inputs seen at the next edge.
    task automatic model_step(input logic [SIZE-1:0] req, input logic [SIZE-1:0] rel);
        int w;
        bit done;
        if (m_gnt < 0) begin
            if (req != '0) begin
                w = -1;
                for (int i = 1; i < SIZE; i++) if (w < 0 && req[i] && m_age[i] == 0) w = i;
                for (int i = 0; i < SIZE; i++) if (w < 0 && req[i]) w = i;
                for (int i = 1; i < SIZE; i++)
                    if (i == w) m_age[i] = TIMEOUT - 1;
                    else if (req[i] && m_age[i] > 0) m_age[i]--;
                m_gnt = w;
                m_len = 0;
            end
        end else begin
            done = !req[m_gnt] || rel[m_gnt];
`ifdef BURST_TIMEOUT_ARBITER_PREEMPT_EN
            if (m_len == MAX_BURST - 1) done = 1;
`endif
            m_len++;
            if (done) m_gnt = -1;
        end
    endtask

    task automatic step(input logic [SIZE-1:0] req, input logic [SIZE-1:0] rel);
        @(negedge clock);
        check("grant", grant, exp_grant());
        check("busy", busy, m_gnt >= 0);
        requests = req;
        releases = rel;
        model_step(req, rel);
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        check("grant", grant, exp_grant());
        check("busy", busy, m_gnt >= 0);
        #1 resetn = 1'b0;
        #1 check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        #1 resetn = 1'b1;
        requests = '0;
        releases = '0;
        model_reset();
    endtask

    initial begin
        logic [SIZE-1:0] rq, rl;
        int n0;
        bit got3;
        model_reset();
        repeat (2) @(negedge clock);
        check("por_grant", grant, 0);
        check("por_busy", busy, 0);
        resetn = 1'b1;

        // Basic grant, release, single idle gap, next grant.
        step(4'b0110, 4'b0000);
        step(4'b0110, 4'b0000);
        check("lock_grant", grant, 4'b0010);
        step(4'b0110, 4'b0010);
        step(4'b0100, 4'b0000);
        check("gap_grant", grant, 4'b0000);
        step(4'b0100, 4'b0001);
        check("next_grant", grant, 4'b0100);
        // Request drop acts as release; other channels' releases are ignored.
        step(4'b0000, 4'b0001);
        step(4'b0000, 4'b0000);
        check("drop_grant", grant, 4'b0000);

        // Aging: channel 3 loses exactly TIMEOUT-1 arbitrations to channel 0.
        reset_pulse();
        n0 = 0;
        got3 = 0;
        for (int c = 0; c < 40 && !got3; c++) begin
            step(4'b1001, 4'b0001);
            if (grant == 4'b0001 && busy) n0++;
            if (grant == 4'b1000) got3 = 1;
        end
        check("age_promoted", got3, 1);
        check("age_lost", n0, TIMEOUT - 1);
        step(4'b1000, 4'b1000);

        // Hold without release: capped when pre-emption is compiled in, held otherwise.
        step(4'b0010, 4'b0000);
        n0 = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 4'b0000);
            if (grant == 4'b0010) n0++;
        end
`ifdef BURST_TIMEOUT_ARBITER_PREEMPT_EN
        check("hold_cycles", n0, 19);
`else
        check("hold_cycles", n0, 20);
`endif
        // Asynchronous reset mid-burst, then a fresh grant one cycle later.
        reset_pulse();
        step(4'b1000, 4'b0000);
        step(4'b1000, 4'b0000);
        check("post_rst_grant", grant, 4'b1000);
        step(4'b0000, 4'b0000);

        rq = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < SIZE; i++) if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
            for (int i = 0; i < SIZE; i++) rl[i] = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 299) == 0) reset_pulse();
            else step(rq, rl);
        end
        @(negedge clock);
        check("grant", grant, exp_grant());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/burst_timeout_arbiter.md
BURST_TIMEOUT_ARBITER -- requirements
Module: burst_timeout_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 4: number of requester channels, at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 8: number of lost arbitrations before a channel is promoted.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum cycles a grant is held when preemption is compiled in.
REQ-004 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port requests, input, SIZE bits: per-channel request, held high for the whole burst.
REQ-007 SHALL have port releases, input, SIZE bits: per-channel last-beat flag, sampled only for the granted channel.
REQ-008 SHALL have port grant, output, SIZE bits: registered grant, one-hot or zero.
REQ-009 SHALL have port busy, output, 1 bit: high in LOCKED state, equal to |grant.

Function
REQ-010 SHALL implement a two-state FSM, IDLE and LOCKED, with grant and state both registered.
REQ-011 IDLE with any request high at cycle N SHALL register the winner, making grant one-hot and entering LOCKED at N+1.
REQ-012 IDLE with no requests SHALL keep grant=0 and stay in IDLE.
REQ-013 Winner selection SHALL work as follows: if any channel has timed out, the lowest-index timed-out requesting channel wins; otherwise the lowest-index requesting channel wins.
REQ-014 Each channel 1..SIZE-1 SHALL own an aging counter of CLOG2(TIMEOUT) bits, reset to TIMEOUT-1; channel 0 has no counter.
REQ-015 On each IDLE arbitration, a channel that requests but does not win SHALL decrement its counter, saturating at 0.
REQ-016 A channel SHALL count as timed out when its counter is 0 and its request is high.
REQ-017 A channel's counter SHALL reload to TIMEOUT-1 on the cycle its grant is registered.
REQ-018 Counters SHALL hold their value in LOCKED state and in IDLE cycles with no arbitration.
REQ-019 LOCKED state SHALL hold grant unchanged while the granted channel's request stays high and its release stays low.
REQ-020 In LOCKED, the granted channel's requests&releases high at cycle M SHALL give grant=0 and IDLE at M+1.
REQ-021 In LOCKED, the granted channel's request dropping at cycle M SHALL count as a release: grant=0 and IDLE at M+1.
REQ-022 Every burst SHALL be followed by exactly one IDLE cycle; back-to-back grants are separated by one cycle with grant=0.
REQ-023 Requests or releases from non-granted channels during LOCKED SHALL have no effect.
REQ-024 Releases SHALL be ignored in IDLE.

Reset
REQ-025 While resetn is low, grant=0, busy=0, state=IDLE and all aging counters=TIMEOUT-1, applied asynchronously.
REQ-026 Reset asserted mid-burst SHALL drop grant immediately; the first grant after deassertion SHALL follow REQ-011.

Configuration
REQ-027 Macro BURST_TIMEOUT_ARBITER_PREEMPT_EN, when defined, SHALL add a CLOG2(MAX_BURST+1)-bit burst counter.
  - The counter clears on grant and increments each LOCKED cycle.
  - The cycle it reaches MAX_BURST-1 SHALL act as a release, so grant lasts at most MAX_BURST cycles.
REQ-028 When BURST_TIMEOUT_ARBITER_PREEMPT_EN is undefined, no burst counter SHALL exist and grant SHALL be held until release or request drop.

Verification
REQ-029 Reset, then requests=4'b0110 at cycle 0 -> grant=4'b0010 at cycle 1; releases[1]=1 at cycle 3 -> grant=0 at 4, grant=4'b0100 at 5.
REQ-030 TIMEOUT=8, channel 0 and channel 3 request continuously, channel 0 bursts 1 cycle each -> channel 3 is granted after 7 lost arbitrations, ahead of channel 0; its counter then reads 7.
REQ-031 Granted channel 2 drops its request with releases=0 -> grant=0 the next cycle; releases[0] pulsed meanwhile changes nothing.
REQ-032 With BURST_TIMEOUT_ARBITER_PREEMPT_EN and MAX_BURST=16, channel 1 holds its request without release -> grant high exactly 16 cycles, then 1 cycle low, then re-granted if still highest; without the macro -> grant stays high indefinitely.
REQ-033 resetn pulsed low mid-burst at cycle 10 -> grant=0 and busy=0 in the same cycle; after deassertion, requests=4'b1000 -> grant=4'b1000 one cycle later.
REQ-034 Channels 1 and 2 both timed out, plus channel 0 requesting -> channel 1 is granted first, then channel 2, then channel 0.
